memory_grid_engine: RTL

//  Parametrised memory-game core: holds per-card state for a COLS x ROWS grid, moves a cursor,

---
 rtl/memory_grid_pkg.sv | 29 ++
 rtl/memory_grid_engine_button_edge.sv | 13 +
 rtl/memory_grid_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/memory_grid_pkg.sv
// memory_grid_pkg: card/game state types, 10-bit colour constants and the pair-id palette
package memory_grid_pkg;
   typedef enum logic [1:0] {FACE_DOWN, FACE_UP, MATCHED} card_state_t;
   typedef enum logic [1:0] {IDLE, ONE_UP, HOLD, WON} game_state_t;
   localparam logic [9:0] C_FULL = 10'd1023;
   localparam logic [9:0] C_HALF = 10'd512;
   localparam logic [9:0] C_GREY = 10'd256;
   localparam logic [9:0] C_ZERO = 10'd0;
   localparam logic [29:0] GREY  = {C_GREY, C_GREY, C_GREY};
   localparam logic [29:0] WHITE = {C_FULL, C_FULL, C_FULL};
   localparam logic [29:0] BLACK = '0;
   localparam logic [29:0] LIME  = {C_ZERO, C_FULL, C_ZERO};

   // ids beyond the ten palette entries wrap round
   function automatic logic [29:0] palette(input int unsigned id);
      case (id % 10)
         0:       return LIME;
         1:       return {C_FULL, C_ZERO, C_FULL};
         2:       return {C_FULL, C_ZERO, C_ZERO};
         3:       return {C_ZERO, C_ZERO, C_FULL};
         4:       return {C_ZERO, C_FULL, C_FULL};
         5:       return {C_FULL, C_FULL, C_ZERO};
         6:       return {C_FULL, C_HALF, C_ZERO};
         7:       return {C_HALF, C_HALF, C_ZERO};
         8:       return {C_HALF, C_ZERO, C_HALF};
         default: return {10'd640, 10'd320, C_ZERO};
      endcase
   endfunction
endpackage

// File: rtl/memory_grid_engine_button_edge.sv
// button_edge: two-flop synchroniser for an active-low button plus a one-cycle press pulse on its falling edge
module button_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);
   logic [2:0] s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s <= '1;
      else s <= {s[1:0], btn_n};
   assign press = s[2] & ~s[1];
endmodule

// File: rtl/memory_grid_engine.sv
// memory_grid_engine: card grid state, cursor, two-card flip/compare game FSM and registered pixel colour.
// Optional CURSOR_BLINK_EN: cursor highlight blinks from a 5-bit frame counter.
module memory_grid_engine
   import memory_grid_pkg::*;
#(
   parameter int COLS          = 5,
   parameter int ROWS          = 4,
   parameter int CARD_W        = 104,
   parameter int CARD_H        = 95,
   parameter int GRID_X0       = 20,
   parameter int GRID_Y0       = 20,
   parameter int GAP           = 20,
   parameter int OFFSET        = 26,
   parameter int REVEAL_FRAMES = 60,
   localparam int NCARDS = COLS * ROWS,
   localparam int ID_W   = $clog2(NCARDS / 2),
   localparam int CUR_W  = $clog2(NCARDS),
   localparam int PF_W   = $clog2(NCARDS / 2 + 1)
) (
   input  logic                   clock_25M,
   input  logic                   reset_n,
   input  logic [9:0]             sx,
   input  logic [9:0]             sy,
   input  logic                   de,
   input  logic                   frame,
   input  logic                   new_game,
   input  logic [NCARDS*ID_W-1:0] deck,
   input  logic                   select_n,
   input  logic                   move_x_n,
   input  logic                   move_y_n,
   output logic [9:0]             paint_r,
   output logic [9:0]             paint_g,
   output logic [9:0]             paint_b,
   output logic [CUR_W-1:0]       cursor,
   output logic [PF_W-1:0]        pairs_found,
   output logic                   game_won
);
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int TMR_W = $clog2(REVEAL_FRAMES + 1);

   logic sel_p, mx_p, my_p, match, show, hx, hy, ix, iy, on_cur;
   logic [COL_W-1:0] col, hc;
   logic [ROW_W-1:0] row, hr;
   logic [CUR_W-1:0] first, second, hidx;
   logic [TMR_W-1:0] timer;
   logic [29:0] pix;
   int px, py;
   game_state_t state;
   card_state_t cards [NCARDS];

   button_edge u_sel (.clk(clock_25M), .rst_n(reset_n), .btn_n(select_n), .press(sel_p));
   button_edge u_mx  (.clk(clock_25M), .rst_n(reset_n), .btn_n(move_x_n), .press(mx_p));
   button_edge u_my  (.clk(clock_25M), .rst_n(reset_n), .btn_n(move_y_n), .press(my_p));

   assign cursor = CUR_W'(int'(col) * ROWS + int'(row));
   assign match  = deck[first*ID_W +: ID_W] == deck[second*ID_W +: ID_W];

   always_ff @(posedge clock_25M or negedge reset_n)
      if (!reset_n) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         cards       <= '{default: FACE_DOWN};
         pairs_found <= '0;
         game_won    <= 1'b0;
         first       <= '0;
         second      <= '0;
         timer       <= '0;
      end else begin
         if (state != WON) begin
            if (my_p) row <= (int'(row) == ROWS - 1) ? '0 : row + 1'b1;
            if (mx_p) col <= (col == '0) ? COL_W'(COLS - 1) : col - 1'b1;
         end
         if (new_game) begin
            state       <= IDLE;
            cards       <= '{default: FACE_DOWN};
            pairs_found <= '0;
            game_won    <= 1'b0;
         end else case (state)
            IDLE: if (sel_p && cards[cursor] == FACE_DOWN) begin
               cards[cursor] <= FACE_UP;
               first         <= cursor;
               state         <= ONE_UP;
            end
            ONE_UP: if (sel_p && cards[cursor] == FACE_DOWN && cursor != first) begin
               cards[cursor] <= FACE_UP;
               second        <= cursor;
               timer         <= TMR_W'(REVEAL_FRAMES);
               state         <= HOLD;
            end
            HOLD: if (timer == '0) begin
               cards[first]  <= match ? MATCHED : FACE_DOWN;
               cards[second] <= match ? MATCHED : FACE_DOWN;
               if (match) pairs_found <= pairs_found + 1'b1;
               state    <= (match && int'(pairs_found) == NCARDS / 2 - 1) ? WON : IDLE;
               game_won <= match && int'(pairs_found) == NCARDS / 2 - 1;
            end else if (frame) timer <= timer - 1'b1;
            default: ;
         endcase
      end

`ifdef CURSOR_BLINK_EN
   logic [4:0] blink;
   always_ff @(posedge clock_25M or negedge reset_n)
      if (!reset_n) blink <= '0;
      else if (frame) blink <= blink + 1'b1;
   assign show = ~blink[4];
`else
   assign show = 1'b1;
`endif

   function automatic int x_of(input int c);
      return GRID_X0 + c * (CARD_W + GAP);
   endfunction

   function automatic int y_of(input int r);
      return GRID_Y0 + r * (CARD_H + GAP);
   endfunction

   assign px = int'(sx);
   assign py = int'(sy);

   // columns and rows never overlap, so a pixel hits at most one of each
   always_comb begin
      hx = 1'b0;
      hy = 1'b0;
      ix = 1'b0;
      iy = 1'b0;
      hc = '0;
      hr = '0;
      for (int c = 0; c < COLS; c++)
         if (px > x_of(c) && px < x_of(c) + CARD_W) begin
            hx = 1'b1;
            hc = COL_W'(c);
            ix = px > x_of(c) + OFFSET && px < x_of(c) + CARD_W - OFFSET;
         end
      for (int r = 0; r < ROWS; r++)
         if (py > y_of(r) && py < y_of(r) + CARD_H) begin
            hy = 1'b1;
            hr = ROW_W'(r);
            iy = py > y_of(r) + OFFSET && py < y_of(r) + CARD_H - OFFSET;
         end
   end

   assign hidx   = CUR_W'(int'(hc) * ROWS + int'(hr));
   assign on_cur = hc == col && hr == row && ix && iy && show;
   assign pix    = !(hx && hy)               ? (game_won ? LIME : BLACK) :
                   on_cur                    ? WHITE :
                   cards[hidx] == FACE_DOWN  ? GREY  :
                   palette(32'(deck[hidx*ID_W +: ID_W]));

   always_ff @(posedge clock_25M or negedge reset_n)
      if (!reset_n) {paint_r, paint_g, paint_b} <= '0;
      else {paint_r, paint_g, paint_b} <= de ? pix : '0;
endmodule
